bambu_getchar: RTL

//  HLS-callable IP implementing bambu_getchar(): returns one received character per call.

---
 rtl/bambu_getchar_pkg.sv | 13 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/bambu_getchar.sv | 88 ++++++++
 3 files changed

// File: rtl/bambu_getchar_pkg.sv
// Shared definitions for the bambu_getchar call interface.
// The transmit-side state machine uses the same one-hot state encoding.
package bambu_getchar_pkg;

   localparam int unsigned DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE = 3'b001,
      PEND = 3'b010,
      POP  = 3'b100
   } t_call_state;

endpackage

// File: rtl/sync_fifo.sv
// Library synchronous FIFO: show-ahead read data, registered full/empty flags.
// Depth must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int unsigned width = 8,
   parameter int unsigned depth = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   i_wr_enable,
   input  logic [width-1:0]       i_wr_data,
   input  logic                   i_rd_enable,
   output logic [width-1:0]       o_rd_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(depth):0] o_count
);

   localparam int unsigned AW = $clog2(depth);
   localparam int unsigned CW = AW + 1;

   logic [width-1:0] r_mem [depth];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    w_count_next;
   logic             r_full;
   logic             r_empty;
   logic             w_push;
   logic             w_pop;

   assign w_push       = i_wr_enable & ~r_full;
   assign w_pop        = i_rd_enable & ~r_empty;
   assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_next;
         r_full  <= (w_count_next == CW'(depth));
         r_empty <= (w_count_next == '0);
      end
   end

   // Storage is not reset; the pointers alone define valid contents.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_full    = r_full;
   assign o_empty   = r_empty;
   assign o_count   = r_count;

endmodule

// File: rtl/bambu_getchar.sv
// HLS-callable getchar: each start_port call returns one byte received from the UART,
// blocking until a byte is available. Bytes arriving with no pending call are buffered.
module bambu_getchar
   import bambu_getchar_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start_port,
   output logic                  done_port,
   output logic [DATA_WIDTH-1:0] return_port,
   input  logic [DATA_WIDTH-1:0] RX_DATA,
   input  logic                  RX_VALID,
   output logic                  RX_OVERRUN
);

   t_call_state           r_state;
   logic                  r_fifo_read;
   logic                  r_done;
   logic [DATA_WIDTH-1:0] r_return;
   logic                  r_overrun;

   logic                  w_wr_enable;
   logic [DATA_WIDTH-1:0] w_wr_data;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic                  w_full;
   logic                  w_empty;

   sync_fifo #(
      .width (DATA_WIDTH)
   ) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .i_wr_enable (w_wr_enable),
      .i_wr_data   (w_wr_data),
      .i_rd_enable (r_fifo_read),
      .o_rd_data   (w_rd_data),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     ()
   );

   assign w_wr_enable = RX_VALID & ~w_full;
   assign w_wr_data   = RX_DATA;

   // A byte on a full FIFO is lost even if a pop frees a slot in the same cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_overrun <= 1'b0;
      end else if (RX_VALID && w_full) begin
         r_overrun <= 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_fifo_read <= 1'b0;
         r_done      <= 1'b0;
         r_return    <= '0;
      end else begin
         r_done      <= 1'b0;
         r_fifo_read <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start_port) r_state <= PEND;
            end
            PEND: begin
               if (!w_empty) begin
                  r_fifo_read <= 1'b1;
                  r_state     <= POP;
               end
            end
            POP: begin
               // Head of the FIFO is visible now; the pop lands at this edge.
               r_return <= w_rd_data;
               r_done   <= 1'b1;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign done_port   = r_done;
   assign return_port = r_return;
   assign RX_OVERRUN  = r_overrun;

endmodule
